// File: rtl/distribute_out_datas_if.sv
// distribute_out_datas_if: serial-in / lane-out bus for distribute_out_datas.
// The master drives the serial word stream; the slave scatters it into lanes.
interface distribute_out_datas_if #(
   parameter int NUM   = 8,
   parameter int WIDTH = 5,
   parameter int CNT_W = 4
);
   logic                 start_i;
   logic [CNT_W-1:0]     len_i;
   logic [WIDTH-1:0]     data_i;
   logic                 valid_i;
   logic                 ready_o;
   logic [NUM*WIDTH-1:0] data_o;
   logic [NUM-1:0]       wr_o;
   logic                 busy_o;
   logic                 done_o;
   modport master (
      output start_i, len_i, data_i, valid_i,
      input  ready_o, data_o, wr_o, busy_o, done_o
   );
   modport slave (
      input  start_i, len_i, data_i, valid_i,
      output ready_o, data_o, wr_o, busy_o, done_o
   );
endinterface

// File: rtl/distribute_out_datas.sv
// distribute_out_datas: scatters a serial word stream into NUM lanes, lane 0 first.
// Define DISTRIBUTE_CLEAR_EN to zero all lanes before each non-empty load.
module distribute_out_datas #(
   parameter int NUM   = 8,
   parameter int WIDTH = 5,
   parameter int CNT_W = 4
) (
   input logic                 clk,
   input logic                 rst,
   distribute_out_datas_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
`ifdef DISTRIBUTE_CLEAR_EN
      CLEAR,
`endif
      LOAD,
      DONE
   } state_t;
   localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM);
   state_t               state, nxt;
   logic [CNT_W-1:0]     len, idx;
   logic [NUM*WIDTH-1:0] data;
   logic [NUM-1:0]       wr;
   logic                 xfer, last;
   assign bus.ready_o = state == LOAD;
   assign bus.busy_o  = state != IDLE;
   assign bus.done_o  = state == DONE;
   assign bus.data_o  = data;
   assign bus.wr_o    = wr;
   assign xfer        = bus.valid_i & bus.ready_o;
   assign last        = idx == len - 1'b1;
   always_comb begin
      nxt = state;
      case (state)
`ifdef DISTRIBUTE_CLEAR_EN
         IDLE:    if (bus.start_i) nxt = bus.len_i == '0 ? DONE : CLEAR;
         CLEAR:   nxt = LOAD;
`else
         IDLE:    if (bus.start_i) nxt = bus.len_i == '0 ? DONE : LOAD;
`endif
         LOAD:    if (xfer && last) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         len   <= '0;
         idx   <= '0;
         data  <= '0;
         wr    <= '0;
      end else begin
         state <= nxt;
         wr    <= '0;
         if (state == IDLE && bus.start_i) begin
            len <= bus.len_i > NUM_C ? NUM_C : bus.len_i;
            idx <= '0;
         end
`ifdef DISTRIBUTE_CLEAR_EN
         if (state == CLEAR) begin
            data <= '0;
            wr   <= '1;
         end
`endif
         // idx saturates on the last word so it never points past NUM-1
         if (xfer) begin
            wr  <= NUM'(1) << idx;
            idx <= last ? idx : idx + 1'b1;
            for (int k = 0; k < NUM; k++)
               if (idx == CNT_W'(k)) data[k*WIDTH +: WIDTH] <= bus.data_i;
         end
      end
   end
endmodule
